// File: rtl/tis_pkg.sv
// tis_pkg: shared core-complex loader constants and the loader state enum
package tis_pkg;
  localparam int NCORES = 12;
  localparam int PWORDS = 15;
  localparam int WORD_W = 16;
  localparam int LEN_W = 4;
  localparam logic [7:0] START_BYTE = 8'hA5;
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    WHI,
    WLO,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    RUN,
    ERR
  } ld_state_e;
endpackage

// File: rtl/ccx_loader.sv
// ccx_loader: byte-stream loader that writes per-core program lengths and words, holding the core complex in reset until done
// Ports: clk/rst (async active-high); in_data/in_valid/in_ready byte stream;
// prog_we/prog_addr/prog_data program memory write; len_we/len_idx/len_data pLength write;
// ccx_rst core complex reset; busy load in progress; err protocol error.
// Build option LOADER_CHECKSUM_EN adds a per-core XOR checksum byte (CHK state).
module ccx_loader
  import tis_pkg::*;
#(
  parameter int NCORES = tis_pkg::NCORES,
  parameter int PWORDS = tis_pkg::PWORDS
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              prog_we,
  output logic [7:0]        prog_addr,
  output logic [WORD_W-1:0] prog_data,
  output logic              len_we,
  output logic [LEN_W-1:0]  len_idx,
  output logic [LEN_W-1:0]  len_data,
  output logic              ccx_rst,
  output logic              busy,
  output logic              err
);
  ld_state_e state_q, state_d;
  logic [3:0] core_q, core_d, word_q, word_d, len_q, len_d;
  logic [7:0] base_q, base_d, hi_q, hi_d;
  logic prog_we_q, prog_we_d, len_we_q, len_we_d, ccx_rst_q, ccx_rst_d;
  logic [7:0] prog_addr_q, prog_addr_d;
  logic [WORD_W-1:0] prog_data_q, prog_data_d;
  logic [LEN_W-1:0] len_idx_q, len_idx_d, len_data_q, len_data_d;
  logic done, eoc;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif
  always_comb begin
    state_d = state_q;
    core_d = core_q;
    word_d = word_q;
    len_d = len_q;
    base_d = base_q;
    hi_d = hi_q;
    prog_we_d = 1'b0;
    len_we_d = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    len_idx_d = len_idx_q;
    len_data_d = len_data_q;
    done = 1'b0;
    eoc = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d = csum_q;
`endif
    if (in_valid) begin
      case (state_q)
        IDLE, RUN, ERR: if (in_data == START_BYTE) begin
          state_d = LEN;
          core_d = '0;
          base_d = '0;
        end
        LEN: if (in_data[7:4] != 4'h0 || int'(in_data[3:0]) > PWORDS) state_d = ERR;
        else begin
          len_we_d = 1'b1;
          len_idx_d = core_q;
          len_data_d = in_data[3:0];
          len_d = in_data[3:0];
          word_d = '0;
          state_d = WHI;
          done = in_data[3:0] == 4'h0;
`ifdef LOADER_CHECKSUM_EN
          csum_d = in_data;
`endif
        end
        WHI: begin
          hi_d = in_data;
          state_d = WLO;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
        end
        WLO: begin
          prog_we_d = 1'b1;
          prog_addr_d = base_q + {4'h0, word_q};
          prog_data_d = {hi_q, in_data};
          state_d = WHI;
          word_d = word_q + 4'd1;
          done = word_q == len_q - 4'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (in_data == csum_q) eoc = 1'b1;
        else state_d = ERR;
`endif
        default: state_d = IDLE;
      endcase
    end
`ifdef LOADER_CHECKSUM_EN
    if (done) state_d = CHK;
`else
    eoc = done;
`endif
    if (eoc) begin
      state_d = core_q == 4'(NCORES - 1) ? RUN : LEN;
      core_d = core_q + 4'd1;
      base_d = base_q + 8'(PWORDS);
    end
    // Held high through the cycle that carries the final write pulse, low once RUN is stable.
    ccx_rst_d = !(state_q == RUN && state_d == RUN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      core_q <= '0;
      word_q <= '0;
      len_q <= '0;
      base_q <= '0;
      hi_q <= '0;
      prog_we_q <= 1'b0;
      len_we_q <= 1'b0;
      ccx_rst_q <= 1'b1;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      len_idx_q <= '0;
      len_data_q <= '0;
    end else begin
      state_q <= state_d;
      core_q <= core_d;
      word_q <= word_d;
      len_q <= len_d;
      base_q <= base_d;
      hi_q <= hi_d;
      prog_we_q <= prog_we_d;
      len_we_q <= len_we_d;
      ccx_rst_q <= ccx_rst_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      len_idx_q <= len_idx_d;
      len_data_q <= len_data_d;
    end
  end
`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else csum_q <= csum_d;
  end
`endif
  assign in_ready = 1'b1;
  assign prog_we = prog_we_q;
  assign prog_addr = prog_addr_q;
  assign prog_data = prog_data_q;
  assign len_we = len_we_q;
  assign len_idx = len_idx_q;
  assign len_data = len_data_q;
  assign ccx_rst = ccx_rst_q;
  assign busy = !(state_q inside {IDLE, RUN, ERR});
  assign err = state_q == ERR;
endmodule

// File: tb/tb_ccx_loader.sv
// tb_ccx_loader: scoreboard bench for ccx_loader write sequences, error and reset behaviour
module tb_ccx_loader;
  localparam int NC = 12;
  localparam int PW = 15;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_ready;
  logic [7:0] in_data = 8'h00;
  logic prog_we, len_we, ccx_rst, busy, err;
  logic [7:0] prog_addr;
  logic [15:0] prog_data;
  logic [3:0] len_idx, len_data;
  typedef struct {bit prog; logic [7:0] addr; logic [15:0] data;} wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  int checks = 0, failures = 0, n_prog = 0, n_len = 0;
  bit stall = 1'b0;
  logic [3:0] lens[NC];
  logic [15:0] wds[NC][PW];
  ccx_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .len_we(len_we), .len_idx(len_idx), .len_data(len_data),
    .ccx_rst(ccx_rst), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && (prog_we || len_we)) begin
      check("we_exclusive", 32'(prog_we && len_we), 0);
      if (prog_we) n_prog++;
      if (len_we) n_len++;
      if (exp_q.size() == 0) check("unexpected_write", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("wr_kind", 32'(prog_we), 32'(mon_e.prog));
        check("wr_addr", prog_we ? 32'(prog_addr) : 32'(len_idx), 32'(mon_e.addr));
        check("wr_data", prog_we ? 32'(prog_data) : 32'(len_data), 32'(mon_e.data));
      end
    end
  end
  task automatic send(input logic [7:0] b);
    if (stall) begin
      in_valid = 1'b0;
      in_data = 8'hA5;
      @(posedge clk); #1;
    end
    in_data = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic load(input int ncores, input bit with_start);
    wr_t e;
    logic [7:0] cs;
    if (with_start) send(8'hA5);
    for (int c = 0; c < ncores; c++) begin
      e.prog = 1'b0; e.addr = 8'(c); e.data = 16'(lens[c]);
      exp_q.push_back(e);
      send({4'h0, lens[c]});
      cs = {4'h0, lens[c]};
      for (int w = 0; w < int'(lens[c]); w++) begin
        e.prog = 1'b1; e.addr = 8'(c * PW + w); e.data = wds[c][w];
        exp_q.push_back(e);
        send(wds[c][w][15:8]);
        send(wds[c][w][7:0]);
        cs = cs ^ wds[c][w][15:8] ^ wds[c][w][7:0];
      end
`ifdef LOADER_CHECKSUM_EN
      send(cs);
`endif
    end
  endtask
  task automatic finish_check(input string tag);
    check({tag, "_rst_hold"}, 32'(ccx_rst), 1);
    @(posedge clk); #1;
    check({tag, "_rst_fall"}, 32'(ccx_rst), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err), 0);
    @(negedge clk); #1;
    check({tag, "_drained"}, 32'(exp_q.size()), 0);
  endtask
  task automatic set_all(input logic [3:0] l, input logic [15:0] w0, input logic [15:0] w1);
    for (int c = 0; c < NC; c++) begin
      lens[c] = l;
      for (int w = 0; w < PW; w++) wds[c][w] = w[0] ? w1 : w0;
    end
  endtask
  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_ccx_rst", 32'(ccx_rst), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_we", 32'({prog_we, len_we}), 0);
    check("rst_addr", 32'({prog_addr, prog_data, len_idx, len_data}), 0);
    check("in_ready", 32'(in_ready), 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(8'h00); send(8'h37);
    check("idle_ignore", 32'({busy, err}), 0);
    set_all(4'd2, 16'h1234, 16'hABCD);
    n_prog = 0; n_len = 0;
    load(NC, 1'b1);
    finish_check("full");
    check("full_nprog", 32'(n_prog), 24);
    check("full_nlen", 32'(n_len), 12);
    stall = 1'b1;
    load(NC, 1'b1);
    stall = 1'b0;
    finish_check("stall");
    set_all(4'd0, 16'h0, 16'h0);
    n_prog = 0;
    load(NC, 1'b1);
    finish_check("zero");
    check("zero_nprog", 32'(n_prog), 0);
    for (int c = 0; c < NC; c++) begin
      lens[c] = (c == 4) ? 4'd15 : 4'(c % 4);
      for (int w = 0; w < PW; w++) wds[c][w] = (w == 1) ? 16'hA5A5 : 16'($urandom);
    end
    load(NC, 1'b1);
    finish_check("varied");
    set_all(4'd0, 16'h0, 16'h0);
    load(3, 1'b1);
    send(8'h10);
    check("bad_err", 32'(err), 1);
    check("bad_ccx_rst", 32'(ccx_rst), 1);
    check("bad_busy", 32'(busy), 0);
    send(8'h00);
    check("err_sticky", 32'(err), 1);
    send(8'hA5);
    check("restart_err", 32'(err), 0);
    check("restart_busy", 32'(busy), 1);
    load(NC, 1'b0);
    finish_check("after_err");
    set_all(4'd2, 16'h1234, 16'hABCD);
    load(6, 1'b1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_we", 32'({prog_we, len_we}), 0);
    check("mid_rst_ccx", 32'(ccx_rst), 1);
    check("mid_rst_busy", 32'({busy, err}), 0);
    check("mid_rst_addr", 32'({prog_addr, prog_data, len_idx, len_data}), 0);
    check("mid_rst_drained", 32'(exp_q.size()), 0);
    @(posedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 32'(busy), 0);
    load(NC, 1'b1);
    finish_check("post_rst");
`ifdef LOADER_CHECKSUM_EN
    lens[0] = 4'd1;
    wds[0][0] = 16'h0102;
    load(1, 1'b1);
    check("csum_pass_err", 32'(err), 0);
    check("csum_pass_busy", 32'(busy), 1);
    lens[1] = 4'd1;
    wds[1][0] = 16'h0102;
    exp_q.push_back('{1'b0, 8'd1, 16'd1});
    send(8'h01);
    exp_q.push_back('{1'b1, 8'(PW), 16'h0102});
    send(8'h01);
    send(8'h02);
    send(8'h03);
    check("csum_bad_err", 32'(err), 1);
    check("csum_bad_ccx", 32'(ccx_rst), 1);
    @(negedge clk); #1;
    check("csum_drained", 32'(exp_q.size()), 0);
`endif
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ccx_loader.md
CCX_LOADER -- requirements
Module: ccx_loader

Interface
REQ-001 The module SHALL have parameter NCORES, default 12, number of cores in the core complex.
REQ-002 The module SHALL have parameter PWORDS, default 15, program words per core; flat program memory depth = NCORES*PWORDS (180).
REQ-003 Port: clk  input  1  single system clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_data  input  8  loader byte stream.
REQ-006 Port: in_valid  input  1  in_data valid.
REQ-007 Port: in_ready  output  1  loader accepts byte; a byte transfers when in_valid && in_ready.
REQ-008 Port: prog_we / prog_addr / prog_data  output  1 / 8 / 16  program memory write strobe, flat address, instruction word.
REQ-009 Port: len_we / len_idx / len_data  output  1 / 4 / 4  pLength write strobe, core index, program length.
REQ-010 Port: ccx_rst  output  1  reset to core complex; high while loading or in error.
REQ-011 Port: busy / err  output  1 / 1  load in progress; protocol error latched.

Function
REQ-012 States SHALL be IDLE, LEN, WHI, WLO, (CHK if enabled), RUN, ERR.
REQ-013 in_ready SHALL be 1 in every state; one byte consumed per cycle maximum, in_valid gaps stall without effect.
REQ-014 IDLE/RUN/ERR: byte 0xA5 -> LEN with core=0, ccx_rst=1, busy=1, err cleared; any other byte ignored.
REQ-015 LEN: byte[7:4]!=0 or byte[3:0]>PWORDS -> ERR; else len_we pulses one cycle later with len_idx=core, len_data=byte[3:0], word=0; next state WHI if length>0, else end-of-core.
REQ-016 WHI latches high byte; WLO completes word; prog_we pulses the cycle after WLO accept with prog_addr=core*PWORDS+word, prog_data={hi,lo}.
REQ-017 After word==length-1 in WLO, or zero length in LEN: end-of-core -> core+1 and LEN, or RUN if core==NCORES-1.
REQ-018 Words at index >= length SHALL NOT be written (memory keeps prior contents).
REQ-019 Entering RUN: ccx_rst deasserts the cycle after the final len_we/prog_we pulse; busy=0.
REQ-020 0xA5 received mid-load (LEN/WHI/WLO) SHALL be treated as data, not restart.
REQ-021 ERR: ccx_rst=1, err=1, busy=0, until 0xA5 received.
REQ-022 prog_we and len_we SHALL never be high in the same cycle.

Reset
REQ-023 On rst: state IDLE, ccx_rst=1, busy=0, err=0, prog_we=0, len_we=0, all addresses/data 0, counters 0; rst mid-load abandons load with no further write pulses.

Configuration
REQ-024 With LOADER_CHECKSUM_EN defined: after each core's last word (or LEN for zero length) state CHK expects one byte equal to XOR of length byte and all data bytes of that core; mismatch -> ERR, match -> end-of-core; writes already issued are not revoked.
REQ-025 Without LOADER_CHECKSUM_EN: no CHK state, no checksum byte in stream.

Structure
REQ-026 Shared package tis_pkg SHALL hold NCORES, PWORDS, word width 16, length width 4, start byte 0xA5 and the loader state enum.
REQ-027 Single flat module; no sub-modules; core*PWORDS computed by an incrementing base register (+PWORDS per core), not a multiplier.

Verification
REQ-028 Full load: A5, 12 cores each length 2 words 0x1234,0xABCD -> 24 prog_we, addr core*15 and core*15+1, 12 len_we data 2, ccx_rst falls after last write.
REQ-029 Zero lengths: A5 then twelve 0x00 -> 12 len_we data 0, no prog_we, RUN.
REQ-030 Bad length 0x10 for core 3 -> ERR, err=1, ccx_rst=1; subsequent A5 clears err and restarts at core 0.
REQ-031 Stalls: same stream as REQ-028 with in_valid low every other cycle -> identical write sequence, ordering preserved.
REQ-032 rst asserted after core 5 word 1 -> outputs to reset values immediately; fresh full load then succeeds.
REQ-033 With LOADER_CHECKSUM_EN: length 1, word 0x0102, checksum 0x02 -> pass; checksum 0x03 -> ERR after the prog_we.
